// File: rtl/udp_pkg.sv
// Shared definitions for the UDP transmit path: staging-buffer FSM states and
// default packet sizing constants used by both the buffer and the transmitter.
package udp_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    READING = 3'd2,
    GAP     = 3'd3,
    FLUSH   = 3'd4
  } fsm_state_e;

  localparam int ETH_HDR_BYTES    = 14;
  localparam int IP_HDR_BYTES     = 20;
  localparam int UDP_HDR_BYTES    = 8;
  localparam int SEQ_BYTES        = 2;
  localparam int DATA_SIZE        = 100;
  localparam int PAYLOAD_SIZE_DEF = DATA_SIZE - SEQ_BYTES;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/udp_payload_buffer_if.sv
// Pixel-side write port, transmitter-side read port and status of the payload buffer.
interface udp_payload_buffer_if #(
  parameter int DEPTH_LOG2 = 12
);
  import udp_pkg::*;

  // Handshake: pix_valid writes a byte with no back-pressure (drops are flagged);
  // the transmitter owns fifo_send_req after send_start and data follows each
  // sampled request by exactly one cycle.
  logic                  pix_valid;
  logic [7:0]            pix_data;
  logic                  frame_start;
  logic                  send_start;
  logic                  fifo_send_req;
  logic [7:0]            fifo_send_data;
  logic                  frame_rst;
  logic [DEPTH_LOG2:0]   fill_level;
  logic                  overflow;
  logic                  underflow;
  logic [15:0]           pkt_cnt;
  fsm_state_e            state;

  modport slave (
    input  pix_valid, pix_data, frame_start, fifo_send_req,
    output send_start, fifo_send_data, frame_rst, fill_level,
           overflow, underflow, pkt_cnt, state
  );

  modport master (
    output pix_valid, pix_data, frame_start, fifo_send_req,
    input  send_start, fifo_send_data, frame_rst, fill_level,
           overflow, underflow, pkt_cnt, state
  );

endinterface

// File: rtl/sync_fifo_bram.sv
// Byte FIFO on a dual-port memory with one-cycle registered read and a
// synchronous clear; an empty read returns 0x00.
module sync_fifo_bram #(
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                wr_en,
  input  logic [7:0]          wr_data,
  input  logic                rd_en,
  output logic [7:0]          rd_data,
  output logic [DEPTH_LOG2:0] level,
  output logic                full,
  output logic                empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  typedef logic [DEPTH_LOG2:0] ptr_t;

  logic [7:0] mem [DEPTH];
  ptr_t       wr_ptr_q, wr_ptr_d;
  ptr_t       rd_ptr_q, rd_ptr_d;
  logic [7:0] rd_data_q;
  logic       wr_fire, rd_fire;

  // One extra pointer bit distinguishes full from empty.
  assign level   = wr_ptr_q - rd_ptr_q;
  assign full    = (level == ptr_t'(DEPTH));
  assign empty   = (level == '0);
  assign wr_fire = wr_en & ~full;
  assign rd_fire = rd_en & ~empty;
  assign rd_data = rd_data_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_fire) wr_ptr_d = wr_ptr_q + ptr_t'(1);
      if (rd_fire) rd_ptr_d = rd_ptr_q + ptr_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr_q[DEPTH_LOG2-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rd_data_q <= 8'h00;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (rd_fire)    rd_data_q <= mem[rd_ptr_q[DEPTH_LOG2-1:0]];
      else if (rd_en) rd_data_q <= 8'h00;
    end
  end

endmodule

// File: rtl/udp_payload_buffer.sv
// Payload staging buffer ahead of the GMII UDP transmitter: requests a packet once a
// full payload is buffered and turns frame_start into a packet-aligned frame_rst.
module udp_payload_buffer
  import udp_pkg::*;
#(
  parameter int PAYLOAD_SIZE = PAYLOAD_SIZE_DEF,
  parameter int DEPTH_LOG2   = 12,
  parameter int GAP_CYCLES   = 16
) (
  input  logic                GMII_GTXCLK,
  input  logic                rst_n,
  udp_payload_buffer_if.slave bus
);

  fsm_state_e          state_q, state_d;
  logic                flush_pending_q, flush_pending_d;
  logic                overflow_q, overflow_d;
  logic                underflow_q, underflow_d;
  logic [15:0]         pkt_cnt_q, pkt_cnt_d;
  logic [15:0]         gap_cnt_q, gap_cnt_d;

  logic [DEPTH_LOG2:0] fill_level;
  logic                fifo_full, fifo_empty;
  logic [7:0]          rd_data;
  logic                flush_req, wr_en, in_flush, level_ok, gap_done;
  logic                send_start, frame_rst;

  // The strobe cycle itself already counts as pending.
  assign flush_req = flush_pending_q | bus.frame_start;
  assign wr_en     = bus.pix_valid & ~flush_req;
  assign in_flush  = (state_q == FLUSH);
  assign level_ok  = 32'(fill_level) >= 32'(PAYLOAD_SIZE);
  assign gap_done  = ({16'd0, gap_cnt_q} + 32'd1) >= 32'(GAP_CYCLES);

  sync_fifo_bram #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_fifo (
    .clk    (GMII_GTXCLK),
    .rst_n  (rst_n),
    .clr    (in_flush),
    .wr_en  (wr_en),
    .wr_data(bus.pix_data),
    .rd_en  (bus.fifo_send_req),
    .rd_data(rd_data),
    .level  (fill_level),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_ff @(posedge GMII_GTXCLK or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (flush_req)     state_d = FLUSH;
        else if (level_ok) state_d = ARMED;
      end
      ARMED:   if (bus.fifo_send_req)  state_d = READING;
      READING: if (!bus.fifo_send_req) state_d = GAP;
      GAP:     if (gap_done)           state_d = flush_req ? FLUSH : IDLE;
      FLUSH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    send_start = 1'b0;
    frame_rst  = 1'b0;
    case (state_q)
      ARMED:   send_start = 1'b1;
      FLUSH:   frame_rst  = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    gap_cnt_d       = (state_q == GAP) ? gap_cnt_q + 16'd1 : 16'd0;
    flush_pending_d = flush_pending_q | bus.frame_start;
    overflow_d      = overflow_q | (wr_en & fifo_full);
    underflow_d     = underflow_q | (bus.fifo_send_req & fifo_empty);
    pkt_cnt_d       = pkt_cnt_q;
    if ((state_q == IDLE) && (state_d == ARMED)) pkt_cnt_d = sat_inc16(pkt_cnt_q);
    // A new frame_start landing on the flush cycle starts a fresh pending flush.
    if (in_flush) begin
      flush_pending_d = bus.frame_start;
      overflow_d      = 1'b0;
      underflow_d     = 1'b0;
      pkt_cnt_d       = 16'd0;
    end
  end

  always_ff @(posedge GMII_GTXCLK or negedge rst_n) begin
    if (!rst_n) begin
      flush_pending_q <= 1'b0;
      overflow_q      <= 1'b0;
      underflow_q     <= 1'b0;
      pkt_cnt_q       <= 16'd0;
      gap_cnt_q       <= 16'd0;
    end else begin
      flush_pending_q <= flush_pending_d;
      overflow_q      <= overflow_d;
      underflow_q     <= underflow_d;
      pkt_cnt_q       <= pkt_cnt_d;
      gap_cnt_q       <= gap_cnt_d;
    end
  end

  assign bus.send_start     = send_start;
  assign bus.frame_rst      = frame_rst;
  assign bus.fifo_send_data = rd_data;
  assign bus.fill_level     = fill_level;
  assign bus.overflow       = overflow_q;
  assign bus.underflow      = underflow_q;
  assign bus.pkt_cnt        = pkt_cnt_q;
  assign bus.state          = state_q;

endmodule

// File: tb/tb_udp_payload_buffer.sv
// Directed-sequence bench for udp_payload_buffer with a queue-based byte model
// and a small transmitter emulation.
module tb_udp_payload_buffer;
  import udp_pkg::*;

  localparam int P     = 98;
  localparam int DL    = 8;
  localparam int GAP   = 16;
  localparam int DEPTH = 1 << DL;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  udp_payload_buffer_if #(.DEPTH_LOG2(DL)) bus ();

  udp_payload_buffer #(
    .PAYLOAD_SIZE(P),
    .DEPTH_LOG2  (DL),
    .GAP_CYCLES  (GAP)
  ) dut (
    .GMII_GTXCLK(clk),
    .rst_n      (rst_n),
    .bus        (bus)
  );

  // Reference model state
  logic [7:0] exp_q[$];
  logic [7:0] last_data = 8'h00;
  bit         ovf_exp = 1'b0;
  bit         unf_exp = 1'b0;
  bit         pend_exp = 1'b0;
  int         pkt_exp = 0;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int src_idx = 0;
  int last_req_cyc = 0;
  bit have_req = 1'b0;
  int frst_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge: check, drive, advance the model across the rising edge.
  task automatic cycle(input logic pv, input logic [7:0] pd, input logic req, input logic fs);
    bit do_flush;
    int sz;
    chk("fill_level", 32'(bus.fill_level), 32'(exp_q.size()));
    chk("overflow", 32'(bus.overflow), 32'(ovf_exp));
    chk("underflow", 32'(bus.underflow), 32'(unf_exp));
    chk("rd_data", 32'(bus.fifo_send_data), 32'(last_data));
    do_flush = (bus.frame_rst === 1'b1);
    if (do_flush) begin
      frst_cnt++;
      if (have_req) chk("frst_after_gap", 32'((cyc - last_req_cyc) > GAP), 32'd1);
    end
    if (req) begin
      last_req_cyc = cyc;
      have_req = 1'b1;
    end
    bus.pix_valid     = pv;
    bus.pix_data      = pd;
    bus.fifo_send_req = req;
    bus.frame_start   = fs;
    @(posedge clk);
    sz = exp_q.size();
    if (req) begin
      if (sz > 0) last_data = exp_q.pop_front();
      else begin
        last_data = 8'h00;
        unf_exp = 1'b1;
      end
    end
    if (fs) pend_exp = 1'b1;
    if (pv && !pend_exp) begin
      if (sz < DEPTH) exp_q.push_back(pd);
      else ovf_exp = 1'b1;
    end
    if (do_flush) begin
      exp_q.delete();
      ovf_exp  = 1'b0;
      unf_exp  = 1'b0;
      pend_exp = 1'b0;
      pkt_exp  = 0;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  // Writes n_wr sequential bytes while serving n_pkts packets as the transmitter would.
  task automatic run(input int n_wr, input int n_pkts, input int fs_at);
    int  wr_left = n_wr;
    int  pkts_left = n_pkts;
    int  rd_left = 0;
    int  rd_idx = 0;
    int  budget = 4000;
    bit  prev_ss = 1'b0;
    bit  have_last = 1'b0;
    bit  chk_fall = 1'b0;
    int  last_rd_cyc = 0;
    logic pv, req, fs, ss;
    logic [7:0] pd;
    while ((wr_left > 0 || pkts_left > 0 || rd_left > 0) && budget > 0) begin
      budget--;
      pv = 1'b0; req = 1'b0; fs = 1'b0; pd = 8'h00;
      ss = bus.send_start;
      if (chk_fall) begin
        chk("ss_fall", 32'(ss), 32'd0);
        chk_fall = 1'b0;
      end
      if (ss && !prev_ss && have_last)
        chk("spacing", 32'((cyc - last_rd_cyc) >= GAP + 2), 32'd1);
      if (ss && rd_left == 0 && pkts_left > 0) begin
        rd_left = P;
        rd_idx = 0;
        pkts_left--;
        pkt_exp++;
        chk("pkt_cnt", 32'(bus.pkt_cnt), 32'(pkt_exp));
        chk_fall = 1'b1;
      end
      if (rd_left > 0) begin
        req = 1'b1;
        rd_left--;
        rd_idx++;
        if (rd_idx == fs_at) fs = 1'b1;
        last_rd_cyc = cyc;
        have_last = 1'b1;
      end
      if (wr_left > 0) begin
        pv = 1'b1;
        pd = 8'(src_idx);
        src_idx++;
        wr_left--;
      end
      prev_ss = ss;
      cycle(pv, pd, req, fs);
    end
    if (budget == 0) chk("run_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.pix_valid     = 1'b0;
    bus.pix_data      = 8'h00;
    bus.frame_start   = 1'b0;
    bus.fifo_send_req = 1'b0;
    #12;
    chk("rst_send_start", 32'(bus.send_start), 32'd0);
    chk("rst_frame_rst", 32'(bus.frame_rst), 32'd0);
    chk("rst_fill", 32'(bus.fill_level), 32'd0);
    chk("rst_pkt_cnt", 32'(bus.pkt_cnt), 32'd0);
    chk("rst_state", 32'(bus.state), 32'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;

    // Single packet 0x00..0x61
    run(P, 1, -1);
    idle(GAP + 4);
    chk("single_pkt_cnt", 32'(bus.pkt_cnt), 32'd1);
    chk("single_fill", 32'(bus.fill_level), 32'd0);

    // Back-to-back: 300 bytes -> three packets and 6 leftovers
    run(300, 3, -1);
    idle(GAP + 4);
    chk("b2b_fill", 32'(bus.fill_level), 32'd6);
    chk("b2b_pkt_cnt", 32'(bus.pkt_cnt), 32'd4);

    // Drain leftovers, then pop an empty FIFO
    repeat (6) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    idle(1);
    chk("unf_flag", 32'(bus.underflow), 32'd1);
    chk("unf_data", 32'(bus.fifo_send_data), 32'd0);

    // Simultaneous read and write at level 5
    run(5, 0, -1);
    cycle(1'b1, 8'(src_idx), 1'b1, 1'b0);
    src_idx++;
    chk("rw_level", 32'(bus.fill_level), 32'd5);
    repeat (5) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    idle(1);

    // Overflow: 260 writes into 256 entries
    src_idx = $urandom_range(0, 255);
    run(260, 0, -1);
    idle(2);
    chk("ovf_fill", 32'(bus.fill_level), 32'(DEPTH));
    chk("ovf_flag", 32'(bus.overflow), 32'd1);
    run(0, 2, -1);
    idle(GAP + 4);
    chk("ovf_left", 32'(bus.fill_level), 32'd60);
    chk("ovf_pkt_cnt", 32'(bus.pkt_cnt), 32'd6);

    // frame_start in the middle of a packet
    frst_cnt = 0;
    run(140, 1, $urandom_range(20, 80));
    idle(GAP + 8);
    chk("flush_once", 32'(frst_cnt), 32'd1);
    chk("flush_fill", 32'(bus.fill_level), 32'd0);
    chk("flush_pkt_cnt", 32'(bus.pkt_cnt), 32'd0);
    chk("flush_ovf", 32'(bus.overflow), 32'd0);
    chk("flush_unf", 32'(bus.underflow), 32'd0);

    // frame_start in IDLE, with a write in the same cycle
    cycle(1'b1, 8'hAA, 1'b0, 1'b1);
    chk("idle_frst", 32'(bus.frame_rst), 32'd1);
    idle(3);
    chk("idle_frst_once", 32'(frst_cnt), 32'd2);
    chk("idle_flush_fill", 32'(bus.fill_level), 32'd0);

    // Asynchronous reset while ARMED
    run(P, 0, -1);
    idle(2);
    chk("armed_ss", 32'(bus.send_start), 32'd1);
    chk("armed_pkt", 32'(bus.pkt_cnt), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_send_start", 32'(bus.send_start), 32'd0);
    chk("arst_fill", 32'(bus.fill_level), 32'd0);
    chk("arst_pkt_cnt", 32'(bus.pkt_cnt), 32'd0);
    chk("arst_data", 32'(bus.fifo_send_data), 32'd0);
    chk("arst_flags", 32'({bus.overflow, bus.underflow, bus.frame_rst}), 32'd0);
    exp_q.delete();
    last_data = 8'h00;
    ovf_exp = 1'b0;
    unf_exp = 1'b0;
    pend_exp = 1'b0;
    pkt_exp = 0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);
    chk("post_rst_state", 32'(bus.state), 32'(IDLE));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
